// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle datapath: next-PC select, run/idle/halt
// control, stall hold and retired-instruction counter. Optional single-step gated by STEP_MODE_EN.
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int RESET_PC    = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   stall,
  input  logic                   haltRequest,
  input  logic                   jumpEnable,
  input  logic                   branchEnable,
  input  logic                   isZero,
  input  logic [31:0]            branchOffset,
  input  logic [25:0]            jumpIndex,
  input  logic                   stepMode,
  input  logic                   stepReq,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic                   fetchValid,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] retireCount,
  output logic                   stepAck
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b11
  } state_t;

  state_t                 curState;
  state_t                 nextState;
  logic [ADDR_WIDTH-1:0]  pcReg;
  logic [COUNT_WIDTH-1:0] countReg;
  logic                   stepOK;
  logic                   retire;
  logic [31:0]            p4Wide;
  logic [31:0]            branchWide;
  logic [31:0]            jumpWide;
  logic [31:0]            nextWide;
  logic                   unusedBits;

  // Target arithmetic is done at full 32-bit width so the jump field keeps its
  // architectural meaning; only the low ADDR_WIDTH bits are kept.
  always_comb begin
    p4Wide     = 32'(pcReg) + 32'd4;
    branchWide = p4Wide + (branchOffset << 2);
    jumpWide   = {p4Wide[31:28], jumpIndex, 2'b00};
    if (jumpEnable)
      nextWide = jumpWide;
    else if (branchEnable && isZero)
      nextWide = branchWide;
    else
      nextWide = p4Wide;
  end

`ifdef STEP_MODE_EN
  logic stepAckReg;

  assign stepOK     = ~stepMode | stepReq;
  assign stepAck    = stepAckReg;
  assign unusedBits = ^nextWide[31:ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (!reset)
      stepAckReg <= 1'b0;
    else
      stepAckReg <= retire & stepMode;
  end
`else
  assign stepOK     = 1'b1;
  assign stepAck    = 1'b0;
  assign unusedBits = ^{nextWide[31:ADDR_WIDTH], stepMode, stepReq};
`endif

  // State register, PC and retire counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      curState <= IDLE;
      pcReg    <= ADDR_WIDTH'(RESET_PC);
      countReg <= '0;
    end else begin
      curState <= nextState;
      if (retire) begin
        pcReg <= nextWide[ADDR_WIDTH-1:0];
        if (countReg != {COUNT_WIDTH{1'b1}})
          countReg <= countReg + COUNT_WIDTH'(1);
      end
    end
  end

  // Next-state logic; HALT is absorbing until reset
  always_comb begin
    nextState = curState;
    case (curState)
      IDLE: if (enable) nextState = RUN;
      RUN: begin
        if (haltRequest)
          nextState = HALT;
        else if (!enable)
          nextState = IDLE;
      end
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fetchValid  = (curState == RUN) & enable & ~stall & ~haltRequest & stepOK;
    retire      = fetchValid;
    halted      = (curState == HALT);
    state       = curState;
    PC          = pcReg;
    retireCount = countReg;
  end

endmodule
